regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised successor to the single-write/dual-read CPU register file.
- Register array width, register count and read-port count are parameters; writes are synchronous with same-cycle write-through bypass; register 0 is hardwired to zero.
- Adds a per-register pending scoreboard: issue marks a destination busy, writeback clears it, and read ports report busy sources so the decode stage can stall.
- Sits between decode (read/alloc) and writeback (write).

Parameters:
- DATA_W, 32, register width in bits
- NUM_REGS, 32, number of registers (power of 2, >=2)
- NUM_RD, 2, number of read ports (1..4)
- ADDR_W, $clog2(NUM_REGS), register index width (derived, do not override)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- rd_addr  in  NUM_RD*ADDR_W  read indices, port i at [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  source register pending, per port
- wr_en  in  1  writeback strobe
- wr_addr  in  ADDR_W  writeback index
- wr_data  in  DATA_W  writeback data
- alloc_en  in  1  issue: mark alloc_addr pending
- alloc_addr  in  ADDR_W  destination being issued
- alloc_stall  out  1  alloc refused (WAW on pending register)
- flush  in  1  clear all pending bits (pipeline flush)

Behaviour:
- Reset (async, rst_n=0): all registers 0, all pending bits 0. The outputs then follow combinationally: rd_busy=0 and alloc_stall=0; rd_data shows register contents (0) or bypassed data when wr_en hits the address.
- Write: on posedge clk with wr_en=1 and wr_addr!=0, reg[wr_addr]<=wr_data and pending[wr_addr]<=0. A write with wr_addr=0 is discarded.
- A write to a non-pending register is legal and updates the data only.
- Read (combinational, zero latency), per port i with address a:
  - a==0 -> rd_data=0, rd_busy=0.
  - wr_en && wr_addr==a -> rd_data=wr_data (bypass), rd_busy=0.
  - otherwise -> rd_data=reg[a], rd_busy=pending[a].
- alloc_stall = alloc_en && alloc_addr!=0 && pending[alloc_addr] && !(wr_en && wr_addr==alloc_addr). This is combinational.
- Alloc: on posedge clk, if alloc_en && !alloc_stall && alloc_addr!=0 && !flush, then pending[alloc_addr]<=1. alloc_addr=0 is a no-op and never stalls.
- Same-cycle write and alloc to the same register: the data is written and the pending bit ends at 1 (alloc wins over clear).
- Flush: on posedge clk, all pending bits <=0. Flush overrides a same-cycle alloc. A same-cycle write still updates data.
- Reset asserted mid-operation: contents and scoreboard are cleared immediately, with no clock required.
- No X propagation: out-of-range indices cannot occur because NUM_REGS is a power of 2.

Optional Feature:
- Macro: REGFILE_PARITY_EN.
- With the macro defined:
  - Each register stores an extra even-parity bit computed from wr_data on write.
  - Added ports: par_err out NUM_RD, and par_inject in 1.
  - par_inject=1 during a write stores inverted parity, for test use.
  - par_err[i] is asserted combinationally when stored parity mismatches reg[a], for a!=0 and not bypassed. Bypassed reads and reads of register 0 report 0.
  - Parity bits reset to 0 (consistent with zero data).
- Without the macro: no parity storage and no par_err/par_inject ports. Behaviour is otherwise identical.

Decomposition:
- Shared package regfile_pkg:
  - REG_ZERO index constant (0).
  - Function clog2_safe.
  - Typedef reg_idx_t sized from the default NUM_REGS, for decode/writeback use.
- One natural sub-module: regfile_scoreboard, which holds the pending vector with the alloc/clear/flush logic and produces alloc_stall and raw pending lookups. The top module holds the data array, bypass mux and parity.

Test Plan:
- Reset then read all registers -> rd_data=0 and rd_busy=0 on every port.
- Write reg5=0xDEADBEEF and read reg5 on port 0 in the same cycle -> rd_data=0xDEADBEEF (bypass). Next cycle, with wr_en=0 -> same value from the array.
- Write reg0=0x12345678 then read reg0 -> 0; alloc reg0 -> alloc_stall=0 and reg0 is never busy.
- Alloc reg7, next cycle read reg7 -> rd_busy=1; alloc reg7 again -> alloc_stall=1. Write reg7=0x55 -> in that cycle rd_busy=0, alloc_stall=0 and rd_data=0x55. Next cycle pending=1 (alloc won).
- Alloc reg3 and reg4 over two cycles, then assert flush together with alloc reg9 -> afterwards reg3/4/9 are all rd_busy=0. Pulse rst_n low between clock edges -> data reads 0 immediately.
- (REGFILE_PARITY_EN) Write reg2=0x1 with par_inject=1, then read reg2 -> par_err=1. Rewrite reg2 with par_inject=0 -> par_err=0. A bypassed read during the injected write -> par_err=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register file and its pending-register scoreboard.
// Index constants and sizing helpers used by decode and writeback.
package regfile_pkg;

  localparam int DEFAULT_NUM_REGS = 32;
  localparam int DEFAULT_ADDR_W   = $clog2(DEFAULT_NUM_REGS);
  localparam int REG_ZERO         = 0;

  typedef logic [DEFAULT_ADDR_W-1:0] reg_idx_t;

  // An index field needs at least one bit even for a two-entry file.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-register scoreboard: issue marks a destination busy, writeback clears it,
// flush clears everything. Produces the WAW alloc stall and the raw pending vector.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = clog2_safe(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic                alloc_en,
  input  logic [ADDR_W-1:0]   alloc_addr,
  input  logic                flush,
  output logic [NUM_REGS-1:0] pending,
  output logic                alloc_stall
);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic                alloc_live;

  // A writeback landing in the same cycle releases the WAW hazard.
  assign alloc_stall = alloc_en && (alloc_addr != ADDR_W'(REG_ZERO)) && pending_q[alloc_addr]
                       && !(wr_en && (wr_addr == alloc_addr));
  assign alloc_live  = alloc_en && !alloc_stall && (alloc_addr != ADDR_W'(REG_ZERO));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    pending_d = pending_q;
    if (wr_en && (wr_addr != ADDR_W'(REG_ZERO))) pending_d[wr_addr] = 1'b0;
    // Ordered after the clear so a same-cycle alloc wins over writeback.
    if (alloc_live) pending_d[alloc_addr] = 1'b1;
    if (flush) pending_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  assign pending = pending_q;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file (1 write, NUM_RD reads, write-through bypass, r0 = 0)
// with pending scoreboard. Optional parity storage enabled by REGFILE_PARITY_EN.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int ADDR_W   = clog2_safe(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  output logic                     alloc_stall,
  input  logic                     flush
`ifdef REGFILE_PARITY_EN
  ,
  output logic [NUM_RD-1:0]        par_err,
  input  logic                     par_inject
`endif
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] pending;
  logic                wr_live;

  assign wr_live = wr_en && (wr_addr != ADDR_W'(REG_ZERO));

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .alloc_en    (alloc_en),
    .alloc_addr  (alloc_addr),
    .flush       (flush),
    .pending     (pending),
    .alloc_stall (alloc_stall)
  );

  always_comb begin
    regs_d = regs_q;
    if (wr_live) regs_d[wr_addr] = wr_data;
  end

  // NOTE: the array is reset on purpose: readers must see zeros immediately after reset,
  // so this stays a flop array rather than an inferred RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs_q <= '{default: '0};
    else        regs_q <= regs_d;
  end

`ifdef REGFILE_PARITY_EN
  logic [NUM_REGS-1:0] par_q, par_d;

  always_comb begin
    par_d = par_q;
    // Even parity; par_inject flips the stored bit to exercise the checker.
    if (wr_live) par_d[wr_addr] = (^wr_data) ^ par_inject;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= '0;
    else        par_q <= par_d;
  end
`endif

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              is_zero;
    logic              bypass;
    logic [DATA_W-1:0] data;
    logic              busy;

    assign addr    = rd_addr[i*ADDR_W +: ADDR_W];
    assign is_zero = (addr == ADDR_W'(REG_ZERO));
    assign bypass  = wr_en && (wr_addr == addr);

    always_comb begin
      data = regs_q[addr];
      busy = pending[addr];
      if (is_zero) begin
        data = '0;
        busy = 1'b0;
      end else if (bypass) begin
        data = wr_data;
        busy = 1'b0;
      end
    end

    assign rd_data[i*DATA_W +: DATA_W] = data;
    assign rd_busy[i]                  = busy;

`ifdef REGFILE_PARITY_EN
    assign par_err[i] = !is_zero && !bypass && (par_q[addr] != (^regs_q[addr]));
`endif
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized traffic
// checked against an array-based model of the register file behaviour.
module tb_regfile_sb;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int NP = 2;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NP*AW-1:0] rd_addr;
  logic [NP*DW-1:0] rd_data;
  logic [NP-1:0]    rd_busy;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            alloc_en;
  logic [AW-1:0]   alloc_addr;
  logic            alloc_stall;
  logic            flush;
`ifdef REGFILE_PARITY_EN
  logic [NP-1:0]   par_err;
  logic            par_inject;
`endif

  int checks = 0;
  int errors = 0;

  // Behavioural model: plain arrays indexed by register number.
  logic [DW-1:0] m_reg  [NR];
  bit            m_pend [NR];
  bit            m_par  [NR];

  regfile_sb dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .alloc_en    (alloc_en),
    .alloc_addr  (alloc_addr),
    .alloc_stall (alloc_stall),
    .flush       (flush)
`ifdef REGFILE_PARITY_EN
    ,
    .par_err     (par_err),
    .par_inject  (par_inject)
`endif
  );

  always #5 clk = ~clk;

  function automatic bit is_byp(int a);
    return (a != 0) && wr_en && (int'(wr_addr) == a);
  endfunction

  function automatic logic [DW-1:0] exp_data(int a);
    if (a == 0) return '0;
    if (is_byp(a)) return wr_data;
    return m_reg[a];
  endfunction

  function automatic bit exp_busy(int a);
    if (a == 0 || is_byp(a)) return 1'b0;
    return m_pend[a];
  endfunction

  function automatic bit exp_stall();
    return alloc_en && (alloc_addr != 0) && m_pend[alloc_addr] && !(wr_en && wr_addr == alloc_addr);
  endfunction

  function automatic bit exp_perr(int a);
    if (a == 0 || is_byp(a)) return 1'b0;
    return m_par[a] != (^m_reg[a]);
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      m_reg[r] = '0; m_pend[r] = 0; m_par[r] = 0;
    end
  endtask

  task automatic set_idle();
    rd_addr = '0; wr_en = 0; wr_addr = '0; wr_data = '0;
    alloc_en = 0; alloc_addr = '0; flush = 0;
`ifdef REGFILE_PARITY_EN
    par_inject = 0;
`endif
  endtask

  task automatic set_rd(int p, int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  // Advance one clock: apply the model update with the inputs held across the edge.
  task automatic tick();
    bit stall;
    bit inj = 0;
    stall = exp_stall();
`ifdef REGFILE_PARITY_EN
    inj = par_inject;
`endif
    @(posedge clk);
    if (wr_en && wr_addr != 0) begin
      m_reg[wr_addr]  = wr_data;
      m_pend[wr_addr] = 0;
      m_par[wr_addr]  = (^wr_data) ^ inj;
    end
    if (alloc_en && !stall && alloc_addr != 0 && !flush) m_pend[alloc_addr] = 1;
    if (flush) for (int r = 0; r < NR; r++) m_pend[r] = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int a = 0; a < NR; a++) begin
      set_rd(0, a); set_rd(1, NR - 1 - a);
      #1;
      for (int p = 0; p < NP; p++) begin
        checks++;
        if (rd_data[p*DW +: DW] !== '0 || rd_busy[p] !== 1'b0) begin
          errors++;
          $display("FAIL reset_read p%0d r%0d: data=%h busy=%b want 0/0", p, a, rd_data[p*DW +: DW], rd_busy[p]);
        end
      end
    end
    checks++;
    if (alloc_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", alloc_stall); end
    @(negedge clk);
  endtask

  task automatic test_bypass();
    set_idle();
    wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; set_rd(0, 5);
    #1;
    checks++;
    if (rd_data[DW-1:0] !== 32'hDEADBEEF || rd_busy[0] !== 1'b0) begin
      errors++; $display("FAIL bypass_same_cycle: data=%h busy=%b want deadbeef/0", rd_data[DW-1:0], rd_busy[0]);
    end
    tick();
    wr_en = 0;
    #1;
    checks++;
    if (rd_data[DW-1:0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL bypass_from_array: data=%h want deadbeef", rd_data[DW-1:0]);
    end
  endtask

  task automatic test_reg0();
    set_idle();
    wr_en = 1; wr_addr = 0; wr_data = 32'h12345678; set_rd(0, 0); set_rd(1, 0);
    #1;
    checks++;
    if (rd_data !== '0) begin errors++; $display("FAIL reg0_write_bypass: data=%h want 0", rd_data); end
    tick();
    wr_en = 0; alloc_en = 1; alloc_addr = 0;
    #1;
    checks++;
    if (rd_data[DW-1:0] !== '0 || alloc_stall !== 1'b0) begin
      errors++; $display("FAIL reg0_read_alloc: data=%h stall=%b want 0/0", rd_data[DW-1:0], alloc_stall);
    end
    tick();
    tick();
    alloc_en = 0;
    #1;
    checks++;
    if (rd_busy[0] !== 1'b0 || alloc_stall !== 1'b0) begin
      errors++; $display("FAIL reg0_never_busy: busy=%b stall=%b want 0/0", rd_busy[0], alloc_stall);
    end
  endtask

  task automatic test_alloc_waw();
    set_idle();
    alloc_en = 1; alloc_addr = 7;
    #1;
    checks++;
    if (alloc_stall !== 1'b0) begin errors++; $display("FAIL waw_first_alloc: stall=%b want 0", alloc_stall); end
    tick();
    set_rd(0, 7);
    #1;
    checks++;
    if (rd_busy[0] !== 1'b1 || alloc_stall !== 1'b1) begin
      errors++; $display("FAIL waw_pending: busy=%b stall=%b want 1/1", rd_busy[0], alloc_stall);
    end
    tick();
    wr_en = 1; wr_addr = 7; wr_data = 32'h55;
    #1;
    checks++;
    if (rd_busy[0] !== 1'b0 || alloc_stall !== 1'b0 || rd_data[DW-1:0] !== 32'h55) begin
      errors++; $display("FAIL waw_writeback: busy=%b stall=%b data=%h want 0/0/55", rd_busy[0], alloc_stall, rd_data[DW-1:0]);
    end
    tick();
    wr_en = 0; alloc_en = 0;
    #1;
    checks++;
    if (rd_busy[0] !== 1'b1 || rd_data[DW-1:0] !== 32'h55) begin
      errors++; $display("FAIL waw_alloc_wins: busy=%b data=%h want 1/55", rd_busy[0], rd_data[DW-1:0]);
    end
  endtask

  task automatic test_flush_reset();
    set_idle();
    alloc_en = 1; alloc_addr = 3; tick();
    alloc_addr = 4; tick();
    alloc_addr = 9; flush = 1; tick();
    set_idle();
    for (int k = 0; k < 3; k++) begin
      int r;
      r = (k == 0) ? 3 : (k == 1) ? 4 : 9;
      set_rd(0, r);
      #1;
      checks++;
      if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL flush_clear r%0d: busy=%b want 0", r, rd_busy[0]); end
    end
    // Async reset between edges with a known nonzero register on port 1.
    set_rd(0, 7); set_rd(1, 5);
    #1;
    checks++;
    if (rd_data[DW +: DW] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL pre_reset_data: data=%h want deadbeef", rd_data[DW +: DW]);
    end
    rst_n = 0;
    model_reset();
    #1;
    checks++;
    if (rd_data !== '0 || rd_busy !== '0) begin
      errors++; $display("FAIL async_reset: data=%h busy=%b want 0/0", rd_data, rd_busy);
    end
    #1 rst_n = 1;
    @(negedge clk);
  endtask

`ifdef REGFILE_PARITY_EN
  task automatic test_parity();
    set_idle();
    wr_en = 1; wr_addr = 2; wr_data = 32'h1; par_inject = 1; set_rd(0, 2);
    #1;
    checks++;
    if (par_err[0] !== 1'b0) begin errors++; $display("FAIL par_bypass: err=%b want 0", par_err[0]); end
    tick();
    set_idle(); set_rd(0, 2);
    #1;
    checks++;
    if (par_err[0] !== 1'b1) begin errors++; $display("FAIL par_injected: err=%b want 1", par_err[0]); end
    wr_en = 1; wr_addr = 2; wr_data = 32'h1;
    tick();
    wr_en = 0;
    #1;
    checks++;
    if (par_err[0] !== 1'b0) begin errors++; $display("FAIL par_clean: err=%b want 0", par_err[0]); end
  endtask
`endif

  task automatic test_random();
    set_idle();
    for (int n = 0; n < 400; n++) begin
      wr_en      = ($urandom_range(0, 1) == 1);
      wr_addr    = AW'($urandom_range(0, 7));
      wr_data    = $urandom;
      alloc_en   = ($urandom_range(0, 2) != 0);
      alloc_addr = AW'($urandom_range(0, 7));
      flush      = ($urandom_range(0, 15) == 0);
      set_rd(0, $urandom_range(0, 7));
      set_rd(1, $urandom_range(0, NR - 1));
`ifdef REGFILE_PARITY_EN
      par_inject = ($urandom_range(0, 3) == 0);
`endif
      #1;
      for (int p = 0; p < NP; p++) begin
        int a;
        a = int'(rd_addr[p*AW +: AW]);
        checks++;
        if (rd_data[p*DW +: DW] !== exp_data(a) || rd_busy[p] !== exp_busy(a)) begin
          errors++;
          $display("FAIL rand_read n%0d p%0d r%0d: data=%h busy=%b want %h/%b", n, p, a,
                   rd_data[p*DW +: DW], rd_busy[p], exp_data(a), exp_busy(a));
        end
`ifdef REGFILE_PARITY_EN
        checks++;
        if (par_err[p] !== exp_perr(a)) begin
          errors++; $display("FAIL rand_par n%0d p%0d: err=%b want %b", n, p, par_err[p], exp_perr(a));
        end
`endif
      end
      checks++;
      if (alloc_stall !== exp_stall()) begin
        errors++; $display("FAIL rand_stall n%0d: stall=%b want %b", n, alloc_stall, exp_stall());
      end
      tick();
    end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_reg0();
    test_alloc_waw();
    test_flush_reset();
`ifdef REGFILE_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
